store_drain_buffer: RTL and testbench

STORE_DRAIN_BUFFER -- requirements
Module: store_drain_buffer

---
 rtl/store_drain_buffer.sv | 159 +++++++++++++++
 tb/tb_store_drain_buffer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// Store buffer: committed stores queue in a circular FIFO and drain one at a time to data memory.
// Loads look up the queued stores and forward the youngest matching data.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module store_drain_buffer #(
  parameter int unsigned SB_NUM = 4,
  parameter int unsigned SB_SEL = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit_valid_1,
  input  logic                 commit_valid_2,
  input  logic [`ADDR_LEN-1:0] commit_addr_1,
  input  logic [`ADDR_LEN-1:0] commit_addr_2,
  input  logic [`DATA_LEN-1:0] commit_data_1,
  input  logic [`DATA_LEN-1:0] commit_data_2,
  output logic                 commit_ack_1,
  output logic                 commit_ack_2,
  output logic                 mem_req,
  output logic [`ADDR_LEN-1:0] mem_addr,
  output logic [`DATA_LEN-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_ack,
  input  logic [`ADDR_LEN-1:0] ld_addr,
  output logic                 fwd_hit,
  output logic [`DATA_LEN-1:0] fwd_data,
  output logic [SB_SEL:0]      sb_free_cnt,
  output logic                 sb_empty
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e               state_q;
  logic [SB_SEL-1:0]    head_q, tail_q, tail_d, next_head, wr_idx_2;
  logic [SB_SEL:0]      count_q, count_d, push_cnt, free_cnt_q;
  logic                 empty_q;
  logic [SB_NUM-1:0]    valid_q;
  logic [`ADDR_LEN-1:0] addr_q [SB_NUM];
  logic [`DATA_LEN-1:0] data_q [SB_NUM];
  logic                 req_q;
  logic [`ADDR_LEN-1:0] mem_addr_q;
  logic [`DATA_LEN-1:0] mem_wdata_q;
  logic                 pop;

  // Acceptance uses only the registered free count; a same-cycle pop never makes room.
  assign commit_ack_1 = commit_valid_1 && (free_cnt_q != '0);
  assign commit_ack_2 = commit_valid_2 &&
                        (commit_valid_1 ? (free_cnt_q >= (SB_SEL+1)'(2)) : (free_cnt_q != '0));

  assign pop       = (state_q == StWait) && mem_ack;
  assign next_head = head_q + SB_SEL'(1);
  assign wr_idx_2  = commit_ack_1 ? tail_q + SB_SEL'(1) : tail_q;
  assign push_cnt  = (SB_SEL+1)'(commit_ack_1) + (SB_SEL+1)'(commit_ack_2);
  assign count_d   = count_q + push_cnt - (SB_SEL+1)'(pop);
  assign tail_d    = tail_q + SB_SEL'(push_cnt);

  assign mem_req     = req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign sb_free_cnt = free_cnt_q;
  assign sb_empty    = empty_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < SB_NUM; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) valid_q[head_q] <= 1'b0;
      if (commit_ack_1) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= commit_addr_1;
        data_q[tail_q]  <= commit_data_1;
      end
      if (commit_ack_2) begin
        valid_q[wr_idx_2] <= 1'b1;
        addr_q[wr_idx_2]  <= commit_addr_2;
        data_q[wr_idx_2]  <= commit_data_2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      free_cnt_q  <= (SB_SEL+1)'(SB_NUM);
      empty_q     <= 1'b1;
      req_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_cnt_q <= (SB_SEL+1)'(SB_NUM) - count_d;
      empty_q    <= (count_d == '0);
      if (pop) head_q <= next_head;
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q     <= StReq;
            req_q       <= 1'b1;
            mem_addr_q  <= addr_q[head_q];
            mem_wdata_q <= data_q[head_q];
          end
        end
        StReq: begin
          if (mem_gnt) begin
            state_q <= StWait;
            req_q   <= 1'b0;
          end
        end
        StWait: begin
          if (mem_ack) begin
            if (count_q > (SB_SEL+1)'(1)) begin
              state_q     <= StReq;
              req_q       <= 1'b1;
              mem_addr_q  <= addr_q[next_head];
              mem_wdata_q <= data_q[next_head];
            end else begin
              state_q     <= StIdle;
              mem_addr_q  <= '0;
              mem_wdata_q <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Valid entries are contiguous from head, so a later loop hit is a younger store.
  always_comb begin
    logic [SB_SEL-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < SB_NUM; i++) begin
      idx = head_q + SB_SEL'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: per-feature tasks with a queue of expected memory writes.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module tb_store_drain_buffer;
  localparam int AW = `ADDR_LEN;
  localparam int DW = `DATA_LEN;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          commit_valid_1 = 1'b0, commit_valid_2 = 1'b0;
  logic [AW-1:0] commit_addr_1 = '0, commit_addr_2 = '0;
  logic [DW-1:0] commit_data_1 = '0, commit_data_2 = '0;
  logic          commit_ack_1, commit_ack_2;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [2:0]    sb_free_cnt;
  logic          sb_empty;

  item_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  store_drain_buffer #(.SB_NUM(4), .SB_SEL(2)) dut (
    .clk(clk), .reset(reset),
    .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
    .commit_addr_1(commit_addr_1), .commit_addr_2(commit_addr_2),
    .commit_data_1(commit_data_1), .commit_data_2(commit_data_2),
    .commit_ack_1(commit_ack_1), .commit_ack_2(commit_ack_2),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .sb_free_cnt(sb_free_cnt), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request, grants it, acks the cycle after the grant.
  task automatic serve_one(output logic [AW-1:0] a, output logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    a  = '0;
    d  = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      a = mem_addr;
      d = mem_wdata;
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem: req=%b addr=%h wdata=%h want 0/0/0", mem_req, mem_addr, mem_wdata);
    end
    n_checks++;
    if (sb_free_cnt !== 3'd4 || sb_empty !== 1'b1 || fwd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: free=%0d empty=%b hit=%b want 4/1/0",
               sb_free_cnt, sb_empty, fwd_hit);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    item_t exp;
    commit_valid_1 = 1'b1;
    commit_addr_1  = AW'(32'h100);
    commit_data_1  = DW'(32'hA5);
    #1;
    n_checks++;
    if (commit_ack_1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: ack1=%b want 1", commit_ack_1);
    end
    sb_q.push_back({AW'(32'h100), DW'(32'hA5)});
    tick();  // edge k
    commit_valid_1 = 1'b0;
    tick();  // edge k+1
    exp = sb_q.pop_front();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp.addr || mem_wdata !== exp.data) begin
      n_fail++;
      $display("FAIL single_req: req=%b addr=%h data=%h want 1 %h %h",
               mem_req, mem_addr, mem_wdata, exp.addr, exp.data);
    end
    mem_gnt = 1'b1;
    tick();  // edge k+2
    mem_gnt = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_wait_req: req=%b want 0", mem_req);
    end
    tick();  // edge k+3
    n_checks++;
    if (sb_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_not_empty: empty=%b want 0", sb_empty);
    end
    mem_ack = 1'b1;
    tick();  // edge k+4
    mem_ack = 1'b0;
    n_checks++;
    if (sb_empty !== 1'b1 || sb_free_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL single_drained: empty=%b free=%0d want 1/4", sb_empty, sb_free_cnt);
    end
  endtask

  task automatic test_full_buffer();
    item_t exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      commit_valid_1 = 1'b1;
      commit_valid_2 = 1'b1;
      commit_addr_1  = AW'(32'h200 + 8 * p);
      commit_data_1  = DW'(32'h20 + 2 * p);
      commit_addr_2  = AW'(32'h204 + 8 * p);
      commit_data_2  = DW'(32'h21 + 2 * p);
      #1;
      n_checks++;
      if (commit_ack_1 !== 1'b1 || commit_ack_2 !== 1'b1) begin
        n_fail++;
        $display("FAIL full_push[%0d]: ack1=%b ack2=%b want 1/1", p, commit_ack_1, commit_ack_2);
      end
      sb_q.push_back({AW'(32'h200 + 8 * p), DW'(32'h20 + 2 * p)});
      sb_q.push_back({AW'(32'h204 + 8 * p), DW'(32'h21 + 2 * p)});
      tick();
    end
    commit_valid_2 = 1'b0;
    commit_addr_1  = AW'(32'h2F0);
    #1;
    n_checks++;
    if (sb_free_cnt !== 3'd0 || commit_ack_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status: free=%0d ack1=%b want 0/0", sb_free_cnt, commit_ack_1);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== sb_q[0].addr || mem_wdata !== sb_q[0].data
          || commit_ack_1 !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: req=%b addr=%h data=%h ack1=%b want 1 %h %h 0",
                 c, mem_req, mem_addr, mem_wdata, commit_ack_1, sb_q[0].addr, sb_q[0].data);
      end
    end
    commit_valid_1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_one(a, d, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok || a !== exp.addr || d !== exp.data) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: ok=%0d addr=%h data=%h want %h %h",
                 i, ok, a, d, exp.addr, exp.data);
      end
    end
  endtask

  task automatic test_dual_commit();
    item_t exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    commit_valid_1 = 1'b1; commit_addr_1 = AW'(32'h300); commit_data_1 = DW'(32'h30);
    commit_valid_2 = 1'b1; commit_addr_2 = AW'(32'h304); commit_data_2 = DW'(32'h31);
    sb_q.push_back({AW'(32'h300), DW'(32'h30)});
    sb_q.push_back({AW'(32'h304), DW'(32'h31)});
    tick();
    commit_valid_2 = 1'b0; commit_addr_1 = AW'(32'h308); commit_data_1 = DW'(32'h32);
    sb_q.push_back({AW'(32'h308), DW'(32'h32)});
    tick();
    commit_valid_1 = 1'b0;
    n_checks++;
    if (sb_free_cnt !== 3'd1) begin
      n_fail++;
      $display("FAIL dual_pre_free: free=%0d want 1", sb_free_cnt);
    end
    commit_valid_1 = 1'b1; commit_addr_1 = AW'(32'h30C); commit_data_1 = DW'(32'h33);
    commit_valid_2 = 1'b1; commit_addr_2 = AW'(32'h310); commit_data_2 = DW'(32'h34);
    #1;
    n_checks++;
    if (commit_ack_1 !== 1'b1 || commit_ack_2 !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_acks: ack1=%b ack2=%b want 1/0", commit_ack_1, commit_ack_2);
    end
    sb_q.push_back({AW'(32'h30C), DW'(32'h33)});
    tick();
    commit_valid_1 = 1'b0;
    commit_valid_2 = 1'b0;
    n_checks++;
    if (sb_free_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL dual_post_free: free=%0d want 0", sb_free_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      serve_one(a, d, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok || a !== exp.addr || d !== exp.data) begin
        n_fail++;
        $display("FAIL dual_drain[%0d]: ok=%0d addr=%h data=%h want %h %h",
                 i, ok, a, d, exp.addr, exp.data);
      end
    end
  endtask

  task automatic test_forwarding();
    item_t exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    ld_addr = AW'(32'h40);
    commit_valid_1 = 1'b1; commit_addr_1 = AW'(32'h40); commit_data_1 = DW'(1);
    #1;
    n_checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      n_fail++;
      $display("FAIL fwd_same_cycle: hit=%b data=%h want 0/0", fwd_hit, fwd_data);
    end
    sb_q.push_back({AW'(32'h40), DW'(1)});
    tick();
    commit_data_1 = DW'(2);
    sb_q.push_back({AW'(32'h40), DW'(2)});
    tick();
    commit_valid_1 = 1'b0;
    #1;
    n_checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== DW'(2)) begin
      n_fail++;
      $display("FAIL fwd_youngest: hit=%b data=%h want 1/2", fwd_hit, fwd_data);
    end
    ld_addr = AW'(32'h44);
    #1;
    n_checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== '0) begin
      n_fail++;
      $display("FAIL fwd_miss: hit=%b data=%h want 0/0", fwd_hit, fwd_data);
    end
    ld_addr = AW'(32'h40);
    for (int i = 0; i < 2; i++) begin
      serve_one(a, d, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok || a !== exp.addr || d !== exp.data) begin
        n_fail++;
        $display("FAIL fwd_drain[%0d]: ok=%0d addr=%h data=%h want %h %h",
                 i, ok, a, d, exp.addr, exp.data);
      end
    end
    #1;
    n_checks++;
    if (fwd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_after_drain: hit=%b want 0", fwd_hit);
    end
  endtask

  task automatic test_wraparound();
    item_t exp;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      commit_valid_1 = 1'b1;
      commit_addr_1  = AW'(32'h500 + 4 * i);
      commit_data_1  = DW'(32'h50 + i);
      #1;
      n_checks++;
      if (commit_ack_1 !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_ack[%0d]: ack1=%b want 1", i, commit_ack_1);
      end
      sb_q.push_back({AW'(32'h500 + 4 * i), DW'(32'h50 + i)});
      tick();
      commit_valid_1 = 1'b0;
      serve_one(a, d, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok || a !== exp.addr || d !== exp.data) begin
        n_fail++;
        $display("FAIL wrap_drain[%0d]: ok=%0d addr=%h data=%h want %h %h",
                 i, ok, a, d, exp.addr, exp.data);
      end
    end
    n_checks++;
    if (sb_empty !== 1'b1 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL wrap_empty: empty=%b addr=%h want 1/0", sb_empty, mem_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    seen = 1'b0;
    commit_valid_1 = 1'b1; commit_addr_1 = AW'(32'h600); commit_data_1 = DW'(32'h60);
    tick();
    commit_valid_1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_wait_req: req=%b want 1 within 20 cycles", mem_req);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || sb_free_cnt !== 3'd4 || sb_empty !== 1'b1 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_async: req=%b free=%0d empty=%b addr=%h want 0/4/1/0",
               mem_req, sb_free_cnt, sb_empty, mem_addr);
    end
    tick();
    reset = 1'b1;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (mem_req !== 1'b0 || sb_free_cnt !== 3'd4 || sb_empty !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_late_ack[%0d]: req=%b free=%0d empty=%b want 0/4/1",
                 c, mem_req, sb_free_cnt, sb_empty);
      end
    end
    mem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full_buffer();
    test_dual_commit();
    test_forwarding();
    test_wraparound();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
